noc_traffic_node: RTL and testbench
===================================

Name: noc_traffic_node

Overview:
- Parametrised NoC endpoint for mesh simulation tops; replaces fixed single-destination test nodes.
- Generator: injects NUM_PKTS packets of PKT_LEN flits to (DEST_X_ID, DEST_Y_ID) with a programmable inter-packet gap.
- Checker: validates every packet received from the router against a fixed flit format, counts packets and raises sticky error flags.
- Optional receive back-pressure mode stresses router buffering.

Parameters:
- DATA_W, 32, flit width; must be >= 4*COORD_W+8.
- COORD_W, 4, width of each X/Y coordinate field.
- X_ID, 0, this node's X coordinate.
- Y_ID, 0, this node's Y coordinate.
- DEST_X_ID, 1, destination X coordinate.
- DEST_Y_ID, 1, destination Y coordinate.
- PKT_LEN, 4, flits per packet including header and tail; minimum 2, maximum 256.
- NUM_PKTS, 16, packets to send; 0 disables the generator.
- GAP, 2, idle cycles between a tail handshake and the next header valid; 0 allowed.
- RX_STALL_PERIOD, 0, 0 holds receive_ready high; N>=2 deasserts it for one cycle in every N.
- CNT_W, 8, width of the packet counters.

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  reset; synchronous, active-high.
- enable  in  1  generator start/run; sampled every cycle.
- receive_valid  in  1  flit valid from router.
- receive_ready  out  1  node accepts flit.
- receive_flit  in  DATA_W  flit from router.
- receive_is_header  in  1  header marker.
- receive_is_tail  in  1  tail marker.
- sender_valid  out  1  flit valid to router.
- sender_ready  in  1  router accepts flit.
- sender_flit  out  DATA_W  flit to router.
- sender_is_header  out  1  header marker.
- sender_is_tail  out  1  tail marker.
- sent_num  out  CNT_W  packets fully sent (tail handshakes).
- receive_num  out  CNT_W  packets received without error.
- err_dest / err_len / err_seq  out  1 each  sticky checker errors.
- done  out  1  generator finished all packets.

Behaviour:
- Transfer occurs when valid && ready on a rising noc_clk edge; the same handshake rule applies on both sides.
- Reset: all outputs 0, except receive_ready = 1 when RX_STALL_PERIOD = 0. Counters, FSM and stall counter are cleared. Reset mid-packet abandons the packet; the router-side flush is the bench's concern.
- Header flit layout:
  - [COORD_W-1:0] dest_x, [2CW-1:CW] dest_y, [3CW-1:2CW] src_x, [4CW-1:3CW] src_y.
  - [4CW+7:4CW] pkt_seq (8-bit, sender-local, wraps 255->0).
  - Upper bits 0.
- Body flit k (k = 1..PKT_LEN-1): [7:0] = k, [15:8] = pkt_seq, upper bits 0.
- Marker bits: sender_is_tail = 1 only on flit PKT_LEN-1; is_header only on flit 0.
- Generator FSM:
  - IDLE -> HEAD when enable && sent_num < NUM_PKTS.
  - HEAD: sender_valid=1 with the header flit; on handshake -> BODY, flit index = 1.
  - BODY: on each handshake the index increments. On the handshake of index PKT_LEN-1 (tail): sent_num++, pkt_seq++, -> GAP_WAIT (GAP>0) or HEAD/DONE.
  - GAP_WAIT: counts GAP cycles, then HEAD if more packets remain, else DONE.
  - DONE: done=1, sender_valid=0; left only by reset.
- enable low: takes effect only in IDLE/GAP_WAIT (no new header). A packet in progress always completes; wormhole packets are never truncated.
- While valid && !ready: flit and markers held stable; valid is never withdrawn.
- First header valid appears the cycle after enable is sampled high in IDLE.
- Checker, acting on each accepted flit:
  - Header while already inside a packet -> err_len. Restart tracking with the new header.
  - Header with dest != (X_ID,Y_ID) -> err_dest.
  - Non-header outside a packet -> err_len.
  - Body index != expected or seq field != header seq -> err_seq.
  - Tail with index != PKT_LEN-1, or index reaching PKT_LEN-1 without tail -> err_len.
  - Tail with no error in the packet -> receive_num++.
- Header and tail on the same flit are an err_len (PKT_LEN >= 2).
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Error flags are sticky until reset.
- Stall mode: a free-running counter modulo RX_STALL_PERIOD drives receive_ready low when the count is RX_STALL_PERIOD-1. Flits are accepted only when ready=1.

Test Plan:
- Loopback (sender wired to receiver through a one-cycle register slice, X_ID=DEST), PKT_LEN=4, NUM_PKTS=3, GAP=2, always-ready -> 12 flits; headers at cycles 1, 7, 13 after enable; sent_num=receive_num=3; done=1; no errors.
- sender_ready held low 5 cycles mid-body -> flit index and data stable throughout; packet completes intact; receive_num=1.
- RX_STALL_PERIOD=3, PKT_LEN=8, 4 packets -> receive_ready low every third cycle; receive_num=4; no errors.
- Inject a header with dest=(2,0) into the node at (0,0) -> err_dest=1; receive_num unchanged.
- Inject header, body k=1, then a new header -> err_len=1. Inject body with k=3 when 2 is expected -> err_seq=1.
- enable dropped after the first header handshake -> packet 1 completes; no second header until enable returns. noc_rst mid-body -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/noc_traffic_node.sv
// NoC traffic endpoint: a packet generator driving the router input and a
// format checker on the router output, with optional receive back-pressure.
module noc_traffic_node #(
    parameter int DATA_W          = 32,
    parameter int COORD_W         = 4,
    parameter int X_ID            = 0,
    parameter int Y_ID            = 0,
    parameter int DEST_X_ID       = 1,
    parameter int DEST_Y_ID       = 1,
    parameter int PKT_LEN         = 4,
    parameter int NUM_PKTS        = 16,
    parameter int GAP             = 2,
    parameter int RX_STALL_PERIOD = 0,
    parameter int CNT_W           = 8
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic              enable,
    input  logic              receive_valid,
    output logic              receive_ready,
    input  logic [DATA_W-1:0] receive_flit,
    input  logic              receive_is_header,
    input  logic              receive_is_tail,
    output logic              sender_valid,
    input  logic              sender_ready,
    output logic [DATA_W-1:0] sender_flit,
    output logic              sender_is_header,
    output logic              sender_is_tail,
    output logic [CNT_W-1:0]  sent_num,
    output logic [CNT_W-1:0]  receive_num,
    output logic              err_dest,
    output logic              err_len,
    output logic              err_seq,
    output logic              done
);
    localparam int          CW       = COORD_W;
    localparam logic [8:0]  LAST     = 9'(PKT_LEN - 1);
    localparam logic [31:0] NUM_U    = 32'(NUM_PKTS);
    localparam logic [31:0] GAP_LAST = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_GAP, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [8:0]        idx;
    logic [7:0]        pkt_seq;
    logic [31:0]       gap_cnt;
    logic [CNT_W-1:0]  sent_cnt;
    logic              tx_fire, tail_fire, more_now, more_after;
    logic [DATA_W-1:0] hdr_flit, body_flit;

    assign tx_fire    = sender_valid && sender_ready;
    assign tail_fire  = tx_fire && (state == S_BODY) && (idx == LAST);
    assign more_now   = 32'(sent_cnt) < NUM_U;
    assign more_after = (32'(sent_cnt) + 32'd1) < NUM_U;
    assign sent_num   = sent_cnt;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // enable is only honoured at packet boundaries so wormholes never truncate
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable && more_now) state_nxt = S_HEAD;
            S_HEAD: if (tx_fire) state_nxt = S_BODY;
            S_BODY: if (tail_fire) begin
                if (GAP > 0)         state_nxt = S_GAP;
                else if (!more_after) state_nxt = S_DONE;
                else if (enable)     state_nxt = S_HEAD;
                else                 state_nxt = S_IDLE;
            end
            S_GAP: if (gap_cnt == GAP_LAST) begin
                if (!more_now)   state_nxt = S_DONE;
                else if (enable) state_nxt = S_HEAD;
                else             state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sender_valid     = 1'b0;
        sender_is_header = 1'b0;
        sender_is_tail   = 1'b0;
        sender_flit      = '0;
        done             = 1'b0;
        case (state)
            S_HEAD: begin
                sender_valid     = 1'b1;
                sender_is_header = 1'b1;
                sender_flit      = hdr_flit;
            end
            S_BODY: begin
                sender_valid   = 1'b1;
                sender_is_tail = (idx == LAST);
                sender_flit    = body_flit;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        hdr_flit               = '0;
        hdr_flit[CW-1:0]       = CW'(DEST_X_ID);
        hdr_flit[2*CW-1:CW]    = CW'(DEST_Y_ID);
        hdr_flit[3*CW-1:2*CW]  = CW'(X_ID);
        hdr_flit[4*CW-1:3*CW]  = CW'(Y_ID);
        hdr_flit[4*CW +: 8]    = pkt_seq;
        body_flit              = '0;
        body_flit[7:0]         = idx[7:0];
        body_flit[15:8]        = pkt_seq;
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            idx      <= '0;
            pkt_seq  <= '0;
            gap_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            if (state == S_HEAD && tx_fire)      idx <= 9'd1;
            else if (state == S_BODY && tx_fire) idx <= idx + 9'd1;
            if (tail_fire) begin
                pkt_seq <= pkt_seq + 8'd1;
                if (sent_cnt != '1) sent_cnt <= sent_cnt + 1'b1;
            end
            gap_cnt <= (state == S_GAP) ? gap_cnt + 32'd1 : 32'd0;
        end
    end

    logic             rx_fire, in_pkt, pkt_err, dest_ok;
    logic             f_len, f_seq, f_dest, f_any;
    logic [8:0]       exp_idx;
    logic [7:0]       cur_seq;
    logic [CNT_W-1:0] rcv_cnt;
    logic             unused_rx_bits;

    assign rx_fire        = receive_valid && receive_ready;
    assign dest_ok        = (receive_flit[CW-1:0] == CW'(X_ID)) &&
                            (receive_flit[2*CW-1:CW] == CW'(Y_ID));
    assign receive_num    = rcv_cnt;
    assign unused_rx_bits = ^receive_flit;

    always_comb begin
        f_len  = 1'b0;
        f_seq  = 1'b0;
        f_dest = 1'b0;
        if (receive_is_header) begin
            f_len  = in_pkt || receive_is_tail;
            f_dest = !dest_ok;
        end else if (!in_pkt) begin
            f_len = 1'b1;
        end else begin
            f_seq = (receive_flit[7:0] != exp_idx[7:0]) || (receive_flit[15:8] != cur_seq);
            f_len = receive_is_tail ? (exp_idx != LAST) : (exp_idx == LAST);
        end
        f_any = pkt_err || f_seq || f_len;
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            in_pkt   <= 1'b0;
            pkt_err  <= 1'b0;
            exp_idx  <= '0;
            cur_seq  <= '0;
            rcv_cnt  <= '0;
            err_dest <= 1'b0;
            err_len  <= 1'b0;
            err_seq  <= 1'b0;
        end else if (rx_fire) begin
            err_dest <= err_dest | f_dest;
            err_len  <= err_len | f_len;
            err_seq  <= err_seq | f_seq;
            if (receive_is_header) begin
                // a new header always restarts tracking, even mid-packet
                in_pkt  <= !receive_is_tail;
                exp_idx <= 9'd1;
                cur_seq <= receive_flit[4*CW +: 8];
                pkt_err <= f_dest;
            end else if (in_pkt) begin
                exp_idx <= exp_idx + 9'd1;
                pkt_err <= f_any;
                if (receive_is_tail || exp_idx == LAST) in_pkt <= 1'b0;
                if (receive_is_tail && !f_any && rcv_cnt != '1) rcv_cnt <= rcv_cnt + 1'b1;
            end
        end
    end

    if (RX_STALL_PERIOD == 0) begin : g_no_stall
        assign receive_ready = 1'b1;
    end else begin : g_stall
        localparam logic [31:0] STALL_LAST = 32'(RX_STALL_PERIOD - 1);
        logic [31:0] stall_cnt, stall_nxt;
        logic        rdy_q;

        assign stall_nxt     = (stall_cnt == STALL_LAST) ? 32'd0 : stall_cnt + 32'd1;
        assign receive_ready = rdy_q;

        // ready is registered alongside the count it is decoded from
        always_ff @(posedge noc_clk) begin
            if (noc_rst) begin
                stall_cnt <= '0;
                rdy_q     <= 1'b0;
            end else begin
                stall_cnt <= stall_nxt;
                rdy_q     <= (stall_nxt != STALL_LAST);
            end
        end
    end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench: loopback node (A), stalled-receiver node (B) and a directly driven
// checker node (C) with a flit scoreboard on A's sender.
module tb_noc_traffic_node;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cyc   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int dx, input int dy, input int sx, input int sy, input int seq);
        return 32'(dx & 15) | (32'(dy & 15) << 4) | (32'(sx & 15) << 8) |
               (32'(sy & 15) << 12) | (32'(seq & 255) << 16);
    endfunction

    function automatic logic [31:0] body(input int k, input int seq);
        return 32'(k & 255) | (32'(seq & 255) << 8);
    endfunction

    typedef struct packed {logic h; logic t; logic [31:0] f;} flit_t;
    flit_t sb_a[$];
    int    hdr_t[$];
    flit_t mon_e;

    // ---------------- node A: loopback through a register slice
    logic        a_rst = 1'b1, a_en = 1'b0, a_sr = 1'b1;
    logic        a_rr, a_sv, a_sh, a_st, a_done, a_ed, a_el, a_es;
    logic [31:0] a_sf;
    logic [7:0]  a_sent, a_rcv;
    logic        sl_v, sl_h, sl_t;
    logic [31:0] sl_f;

    always @(posedge clk) begin
        if (a_rst) begin
            sl_v <= 1'b0; sl_h <= 1'b0; sl_t <= 1'b0; sl_f <= '0;
        end else begin
            sl_v <= a_sv && a_sr; sl_h <= a_sh; sl_t <= a_st; sl_f <= a_sf;
        end
    end

    noc_traffic_node #(.X_ID(1), .Y_ID(1), .DEST_X_ID(1), .DEST_Y_ID(1),
                       .PKT_LEN(4), .NUM_PKTS(3), .GAP(2)) u_a (
        .noc_clk(clk), .noc_rst(a_rst), .enable(a_en),
        .receive_valid(sl_v), .receive_ready(a_rr), .receive_flit(sl_f),
        .receive_is_header(sl_h), .receive_is_tail(sl_t),
        .sender_valid(a_sv), .sender_ready(a_sr), .sender_flit(a_sf),
        .sender_is_header(a_sh), .sender_is_tail(a_st),
        .sent_num(a_sent), .receive_num(a_rcv),
        .err_dest(a_ed), .err_len(a_el), .err_seq(a_es), .done(a_done));

    always @(negedge clk) begin
        if (!a_rst && a_sv && a_sr) begin
            if (a_sh) hdr_t.push_back(cyc - en_cyc);
            n_checks++;
            assert (sb_a.size() != 0) else begin
                n_fail++;
                $error("FAIL a_extra_flit: observed flit 0x%0h expected none", a_sf);
            end
            if (sb_a.size() != 0) begin
                mon_e = sb_a.pop_front();
                check("a_flit", 64'({a_sh, a_st, a_sf}), 64'({mon_e.h, mon_e.t, mon_e.f}));
            end
        end
    end

    task automatic push_pkt(input int seq);
        sb_a.push_back('{h: 1'b1, t: 1'b0, f: hdr(1, 1, 1, 1, seq)});
        for (int k = 1; k < 4; k++) sb_a.push_back('{h: 1'b0, t: (k == 3), f: body(k, seq)});
    endtask

    task automatic reset_a();
        @(posedge clk); #1;
        a_rst = 1'b1; a_en = 1'b0;
        @(posedge clk); #1;
        a_rst = 1'b0;
        sb_a.delete();
        hdr_t.delete();
    endtask

    task automatic start_a();
        a_en = 1'b1;
        en_cyc = cyc;
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 300 && !a_done; i++) @(negedge clk);
        check(tag, 64'(a_done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- node B: receiver back-pressure, wired straight back
    logic        b_rst = 1'b1, b_en = 1'b0;
    logic        b_rr, b_sv, b_sh, b_st, b_done, b_ed, b_el, b_es;
    logic [31:0] b_sf;
    logic [7:0]  b_sent, b_rcv;

    noc_traffic_node #(.X_ID(2), .Y_ID(3), .DEST_X_ID(2), .DEST_Y_ID(3),
                       .PKT_LEN(8), .NUM_PKTS(4), .GAP(1), .RX_STALL_PERIOD(3)) u_b (
        .noc_clk(clk), .noc_rst(b_rst), .enable(b_en),
        .receive_valid(b_sv), .receive_ready(b_rr), .receive_flit(b_sf),
        .receive_is_header(b_sh), .receive_is_tail(b_st),
        .sender_valid(b_sv), .sender_ready(b_rr), .sender_flit(b_sf),
        .sender_is_header(b_sh), .sender_is_tail(b_st),
        .sent_num(b_sent), .receive_num(b_rcv),
        .err_dest(b_ed), .err_len(b_el), .err_seq(b_es), .done(b_done));

    // ---------------- node C at (0,0): checker driven directly, 2-bit counters
    logic        c_rst = 1'b1, c_en = 1'b0, c_rv = 1'b0, c_rh = 1'b0, c_rt = 1'b0;
    logic [31:0] c_rf = '0;
    logic        c_rr, c_sv, c_sh, c_st, c_done, c_ed, c_el, c_es;
    logic [31:0] c_sf;
    logic [1:0]  c_sent, c_rcv;

    noc_traffic_node #(.X_ID(0), .Y_ID(0), .PKT_LEN(4), .NUM_PKTS(0), .CNT_W(2)) u_c (
        .noc_clk(clk), .noc_rst(c_rst), .enable(c_en),
        .receive_valid(c_rv), .receive_ready(c_rr), .receive_flit(c_rf),
        .receive_is_header(c_rh), .receive_is_tail(c_rt),
        .sender_valid(c_sv), .sender_ready(1'b1), .sender_flit(c_sf),
        .sender_is_header(c_sh), .sender_is_tail(c_st),
        .sent_num(c_sent), .receive_num(c_rcv),
        .err_dest(c_ed), .err_len(c_el), .err_seq(c_es), .done(c_done));

    task automatic inj(input logic [31:0] f, input logic h, input logic t);
        c_rv = 1'b1; c_rf = f; c_rh = h; c_rt = t;
        @(posedge clk); #1;
        c_rv = 1'b0; c_rf = '0; c_rh = 1'b0; c_rt = 1'b0;
    endtask

    task automatic inj_pkt(input int dx, input int dy, input int seq);
        inj(hdr(dx, dy, 3, 3, seq), 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) inj(body(k, seq), 1'b0, (k == 3));
    endtask

    task automatic reset_c();
        c_rst = 1'b1;
        @(posedge clk); #1;
        c_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clk);
        check("a_rst_out", 64'({a_sv, a_sh, a_st, a_done, a_ed, a_el, a_es}), 64'd0);
        check("a_rst_flit", 64'(a_sf), 64'd0);
        check("a_rst_cnt", 64'({a_sent, a_rcv}), 64'd0);
        check("a_rst_ready", 64'(a_rr), 64'd1);
        check("b_rst_ready", 64'(b_rr), 64'd0);

        // loopback, 3 packets, gap 2
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) push_pkt(s);
        start_a();
        wait_done_a("a_loop_done");
        check("a_loop_sent", 64'(a_sent), 64'd3);
        check("a_loop_rcv", 64'(a_rcv), 64'd3);
        check("a_loop_err", 64'({a_ed, a_el, a_es}), 64'd0);
        check("a_loop_valid_done", 64'(a_sv), 64'd0);
        check("a_loop_sb_left", 64'(sb_a.size()), 64'd0);
        check("a_hdr_cnt", 64'(hdr_t.size()), 64'd3);
        check("a_hdr_t0", 64'(hdr_t.size() > 0 ? hdr_t[0] : -1), 64'd1);
        check("a_hdr_t1", 64'(hdr_t.size() > 1 ? hdr_t[1] : -1), 64'd7);
        check("a_hdr_t2", 64'(hdr_t.size() > 2 ? hdr_t[2] : -1), 64'd13);

        // router back-pressure mid-body
        reset_a();
        for (int s = 0; s < 3; s++) push_pkt(s);
        start_a();
        repeat (2) begin @(posedge clk); #1; end
        a_sr = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("a_stall_valid", 64'(a_sv), 64'd1);
            check("a_stall_flit", 64'({a_sh, a_st, a_sf}), 64'({2'b00, body(1, 0)}));
        end
        @(posedge clk); #1;
        a_sr = 1'b1;
        for (int i = 0; i < 50 && a_rcv == 0; i++) @(negedge clk);
        check("a_stall_rcv1", 64'(a_rcv), 64'd1);
        check("a_stall_err", 64'({a_ed, a_el, a_es}), 64'd0);
        wait_done_a("a_stall_done");
        check("a_stall_rcv3", 64'(a_rcv), 64'd3);

        // enable dropped after the first header handshake
        reset_a();
        push_pkt(0);
        start_a();
        repeat (2) begin @(posedge clk); #1; end
        a_en = 1'b0;
        repeat (20) @(negedge clk);
        check("a_drop_sent", 64'(a_sent), 64'd1);
        check("a_drop_hdrs", 64'(hdr_t.size()), 64'd1);
        check("a_drop_idle", 64'({a_sv, a_done}), 64'd0);
        @(posedge clk); #1;
        push_pkt(1);
        push_pkt(2);
        a_en = 1'b1;
        wait_done_a("a_drop_done");
        check("a_drop_sent3", 64'(a_sent), 64'd3);
        check("a_drop_rcv3", 64'(a_rcv), 64'd3);
        check("a_drop_sb_left", 64'(sb_a.size()), 64'd0);

        // reset in the middle of the second packet body
        reset_a();
        for (int s = 0; s < 3; s++) push_pkt(s);
        start_a();
        for (int i = 0; i < 100 && !(a_sent == 1 && a_sv && !a_sh); i++) @(negedge clk);
        check("a_midbody_reached", 64'(a_sent == 1 && a_sv && !a_sh), 64'd1);
        @(posedge clk); #1;
        a_rst = 1'b1; a_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("a_mrst_out", 64'({a_sv, a_sh, a_st, a_done, a_ed, a_el, a_es}), 64'd0);
        check("a_mrst_flit", 64'(a_sf), 64'd0);
        check("a_mrst_cnt", 64'({a_sent, a_rcv}), 64'd0);
        check("a_mrst_ready", 64'(a_rr), 64'd1);
        @(posedge clk); #1;
        a_rst = 1'b0;
        sb_a.delete();

        // receiver stall every third cycle
        b_en = 1'b1;
        repeat (5) @(negedge clk);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!b_rr) lows++;
        end
        check("b_ready_lows", 64'(lows), 64'd10);
        for (int i = 0; i < 500 && !b_done; i++) @(negedge clk);
        check("b_done", 64'(b_done), 64'd1);
        repeat (3) @(negedge clk);
        check("b_sent", 64'(b_sent), 64'd4);
        check("b_rcv", 64'(b_rcv), 64'd4);
        check("b_err", 64'({b_ed, b_el, b_es}), 64'd0);

        // direct injection into node (0,0)
        @(posedge clk); #1;
        c_en = 1'b1;
        for (int s = 5; s < 8; s++) inj_pkt(0, 0, s);
        @(negedge clk);
        check("c_rcv3", 64'(c_rcv), 64'd3);
        check("c_gen_off", 64'({c_sv, c_done, c_sent}), 64'd0);
        @(posedge clk); #1;
        inj_pkt(0, 0, 255);
        inj_pkt(0, 0, 0);
        @(negedge clk);
        check("c_rcv_sat", 64'(c_rcv), 64'd3);
        check("c_good_err", 64'({c_ed, c_el, c_es}), 64'd0);

        @(posedge clk); #1;
        reset_c();
        inj_pkt(2, 0, 1);
        @(negedge clk);
        check("c_dest_flags", 64'({c_ed, c_el, c_es}), 64'b100);
        check("c_dest_rcv", 64'(c_rcv), 64'd0);

        @(posedge clk); #1;
        reset_c();
        inj(hdr(0, 0, 3, 3, 1), 1'b1, 1'b0);
        inj(body(1, 1), 1'b0, 1'b0);
        inj(hdr(0, 0, 3, 3, 2), 1'b1, 1'b0);
        @(negedge clk);
        check("c_hdr_in_pkt", 64'({c_ed, c_el, c_es}), 64'b010);

        @(posedge clk); #1;
        reset_c();
        inj(hdr(0, 0, 3, 3, 4), 1'b1, 1'b0);
        inj(body(1, 4), 1'b0, 1'b0);
        inj(body(3, 4), 1'b0, 1'b0);
        @(negedge clk);
        check("c_idx_skip", 64'({c_ed, c_el, c_es}), 64'b001);

        @(posedge clk); #1;
        reset_c();
        inj(hdr(0, 0, 3, 3, 4), 1'b1, 1'b0);
        inj(body(1, 9), 1'b0, 1'b0);
        @(negedge clk);
        check("c_seq_field", 64'({c_ed, c_el, c_es}), 64'b001);

        @(posedge clk); #1;
        reset_c();
        inj(hdr(0, 0, 3, 3, 0), 1'b1, 1'b1);
        @(negedge clk);
        check("c_hdr_tail", 64'({c_ed, c_el, c_es}), 64'b010);

        @(posedge clk); #1;
        reset_c();
        inj(body(1, 0), 1'b0, 1'b0);
        @(negedge clk);
        check("c_orphan_body", 64'({c_ed, c_el, c_es}), 64'b010);

        @(posedge clk); #1;
        reset_c();
        inj(hdr(0, 0, 3, 3, 6), 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) inj(body(k, 6), 1'b0, 1'b0);
        @(negedge clk);
        check("c_no_tail", 64'({c_ed, c_el, c_es}), 64'b010);
        check("c_no_tail_rcv", 64'(c_rcv), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
